pattern_memory_arbiter: RTL



---
 rtl/pattern_memory_pkg.sv | 20 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/pattern_memory_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_memory_pkg.sv
// Shared types and default sizes for the actuator pattern memory arbiter.
package pattern_memory_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int READ_LAT_DEF = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_PLAY = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between host (port 0) and playback (port 1).
// ARB_ROUND_ROBIN_EN selects round-robin; otherwise port 0 has fixed priority.
module mem_arb_pick
  import pattern_memory_pkg::*;
(
  input  logic   req_0,
  input  logic   req_1,
  input  owner_e last_grant,
  output owner_e winner,
  output logic   any_req
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    any_req = req_0 | req_1;
    winner  = OWNER_HOST;
    if (req_0 && req_1) begin
      // Contested: the port that did not win last time goes first.
      winner = (last_grant == OWNER_HOST) ? OWNER_PLAY : OWNER_HOST;
    end else if (req_1) begin
      winner = OWNER_PLAY;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    any_req = req_0 | req_1;
    winner  = (!req_0 && req_1) ? OWNER_PLAY : OWNER_HOST;
  end
`endif

endmodule

// File: rtl/pattern_memory_arbiter.sv
// Two-port arbiter in front of the single-port pattern memory macro.
// ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: port 0 priority).
module pattern_memory_arbiter
  import pattern_memory_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int READ_LAT = READ_LAT_DEF  // legal range 1..7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_n,
  input  logic              req_valid_n_0,
  input  logic              req_write_n_0,
  input  logic [ADDR_W-1:0] req_address_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              req_grant_n_0,
  output logic [DATA_W-1:0] req_rdata_0,
  output logic              req_rvalid_n_0,
  input  logic              req_valid_n_1,
  input  logic              req_write_n_1,
  input  logic [ADDR_W-1:0] req_address_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              req_grant_n_1,
  output logic [DATA_W-1:0] req_rdata_1,
  output logic              req_rvalid_n_1,
  output logic              memory_enable_n,
  output logic              memory_write_n,
  output logic              memory_read_n,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data_out,
  input  logic [DATA_W-1:0] memory_data_in,
  output logic              busy
);

  localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            winner, last_grant;
  logic              any_req, grant_go;
  logic [2:0]        cnt_q, cnt_d;
  logic              grant_n_0_q, grant_n_0_d, grant_n_1_q, grant_n_1_d;
  logic              rvalid_n_0_q, rvalid_n_0_d, rvalid_n_1_q, rvalid_n_1_d;
  logic [DATA_W-1:0] rdata_0_q, rdata_0_d, rdata_1_q, rdata_1_d;
  logic              mem_en_n_q, mem_en_n_d, mem_wr_n_q, mem_wr_n_d;
  logic              mem_rd_n_q, mem_rd_n_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_dout_q, mem_dout_d;
  logic              busy_q, busy_d;
  logic              sel_write_n;

  mem_arb_pick u_pick (
    .req_0      (~req_valid_n_0),
    .req_1      (~req_valid_n_1),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign grant_go    = (state_q == IDLE) && !enable_n && any_req;
  assign sel_write_n = (winner == OWNER_PLAY) ? req_write_n_1 : req_write_n_0;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = grant_go ? winner : last_grant_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_grant_q <= OWNER_PLAY;  // makes port 0 win the first contest
    else       last_grant_q <= last_grant_d;
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = OWNER_PLAY;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    state_d      = state_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    rdata_0_d    = rdata_0_q;
    rdata_1_d    = rdata_1_q;
    mem_addr_d   = mem_addr_q;
    mem_dout_d   = mem_dout_q;
    grant_n_0_d  = 1'b1;
    grant_n_1_d  = 1'b1;
    rvalid_n_0_d = 1'b1;
    rvalid_n_1_d = 1'b1;
    mem_en_n_d   = 1'b1;
    mem_wr_n_d   = 1'b1;
    mem_rd_n_d   = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (grant_go) begin
          owner_d     = winner;
          mem_addr_d  = (winner == OWNER_PLAY) ? req_address_1 : req_address_0;
          mem_dout_d  = (winner == OWNER_PLAY) ? req_wdata_1 : req_wdata_0;
          grant_n_0_d = (winner != OWNER_HOST);
          grant_n_1_d = (winner != OWNER_PLAY);
          mem_en_n_d  = 1'b0;
          mem_wr_n_d  = sel_write_n;
          mem_rd_n_d  = ~sel_write_n;
          state_d     = CMD;
        end
      end
      CMD: begin
        if (!mem_rd_n_q) begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end else begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          if (owner_q == OWNER_PLAY) begin
            rdata_1_d    = memory_data_in;
            rvalid_n_1_d = 1'b0;
          end else begin
            rdata_0_d    = memory_data_in;
            rvalid_n_0_d = 1'b0;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWNER_HOST;
      cnt_q        <= '0;
      grant_n_0_q  <= 1'b1;
      grant_n_1_q  <= 1'b1;
      rvalid_n_0_q <= 1'b1;
      rvalid_n_1_q <= 1'b1;
      rdata_0_q    <= '0;
      rdata_1_q    <= '0;
      mem_en_n_q   <= 1'b1;
      mem_wr_n_q   <= 1'b1;
      mem_rd_n_q   <= 1'b1;
      mem_addr_q   <= '0;
      mem_dout_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      grant_n_0_q  <= grant_n_0_d;
      grant_n_1_q  <= grant_n_1_d;
      rvalid_n_0_q <= rvalid_n_0_d;
      rvalid_n_1_q <= rvalid_n_1_d;
      rdata_0_q    <= rdata_0_d;
      rdata_1_q    <= rdata_1_d;
      mem_en_n_q   <= mem_en_n_d;
      mem_wr_n_q   <= mem_wr_n_d;
      mem_rd_n_q   <= mem_rd_n_d;
      mem_addr_q   <= mem_addr_d;
      mem_dout_q   <= mem_dout_d;
      busy_q       <= busy_d;
    end
  end

  assign req_grant_n_0   = grant_n_0_q;
  assign req_grant_n_1   = grant_n_1_q;
  assign req_rvalid_n_0  = rvalid_n_0_q;
  assign req_rvalid_n_1  = rvalid_n_1_q;
  assign req_rdata_0     = rdata_0_q;
  assign req_rdata_1     = rdata_1_q;
  assign memory_enable_n = mem_en_n_q;
  assign memory_write_n  = mem_wr_n_q;
  assign memory_read_n   = mem_rd_n_q;
  assign memory_address  = mem_addr_q;
  assign memory_data_out = mem_dout_q;
  assign busy            = busy_q;

endmodule
